// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Imported by the fetch control logic and its instruction buffer.
package fetch_queue_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction buffer holding fetched {pc, instr} pairs.
// Flush empties it in one cycle and wins over push/pop.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head_entry,
    output logic [CW-1:0] count
);

    fetch_entry_t mem [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    // Gate the head so an empty buffer always presents zeros.
    assign head_entry = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst)
        !(push && full && !pop && !flush)
    );

endmodule

// File: rtl/fetch_queue.sv
// Fetch control: one outstanding imem request, redirect squashing,
// and a small decoupling buffer toward decode.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] pending_pc;
    logic            outstanding;
    logic            squash;
    logic [CW-1:0]   count;
    fetch_entry_t    head_entry;
    fetch_entry_t    push_entry;
    logic            req_fire;
    logic            rsp_fire;
    logic            push;
    logic            pop;

    // With nothing outstanding, occupancy alone bounds the next request.
    assign imem_req_valid = !rst && !outstanding && !redirect_valid
                            && (count < CW'(DEPTH));
    assign imem_req_addr  = fetch_pc;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_fire = imem_rsp_valid && outstanding;

    assign instr_valid = (count != '0);
    assign push        = rsp_fire && !squash && !redirect_valid;
    assign pop         = instr_valid && instr_ready && !redirect_valid;

    assign push_entry.pc    = pending_pc;
    assign push_entry.instr = imem_rsp_data;

    assign instr    = head_entry.instr;
    assign instr_pc = head_entry.pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            pending_pc  <= RESET_PC;
            outstanding <= 1'b0;
            squash      <= 1'b0;
        end else begin
            if (redirect_valid)
                fetch_pc <= redirect_pc & ~XLEN'(INSTR_BYTES - 1);
            else if (req_fire)
                fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);

            if (req_fire) pending_pc <= fetch_pc;

            if (req_fire)      outstanding <= 1'b1;
            else if (rsp_fire) outstanding <= 1'b0;

            // A response in the redirect cycle is dropped directly.
            if (rsp_fire)
                squash <= 1'b0;
            else if (redirect_valid && outstanding)
                squash <= 1'b1;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_entry(push_entry),
        .pop       (pop),
        .head_entry(head_entry),
        .count     (count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a small latency-programmable
// instruction memory model driven from the bench tasks.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int checks = 0;
    int failures = 0;

    int          mem_lat;
    bit          mem_auto;
    int          lat_cnt;
    logic [31:0] lat_addr;
    logic [31:0] fire_q [$];

    localparam int DEPTH = 2;

    fetch_queue #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[23:0], 8'h13};
    endfunction

    // One clock: note a request transfer, step the edge, drive the response.
    task automatic cycle();
        #1;
        if (imem_req_valid && imem_req_ready) begin
            lat_cnt  = mem_lat;
            lat_addr = imem_req_addr;
            fire_q.push_back(imem_req_addr);
        end
        @(posedge clk);
        @(negedge clk);
        if (mem_auto) begin
            imem_rsp_valid = 1'b0;
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = word(lat_addr);
                end
            end
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b1;
        lat_cnt        = 0;
        mem_auto       = 1'b1;
        mem_lat        = 1;
        fire_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        instr_ready = 1'b0;
        repeat (3) cycle();
        checks++;
        if (instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_valid: got %b expected 1", instr_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid);
        end
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_instr_valid: got %b expected 0", instr_valid);
        end
        checks++;
        if (imem_req_addr !== 32'h0) begin
            failures++;
            $display("FAIL rst_addr: got %h expected 00000000", imem_req_addr);
        end
        checks++;
        if (instr !== 32'h0) begin
            failures++;
            $display("FAIL rst_instr: got %h expected 00000000", instr);
        end
        checks++;
        if (instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL rst_instr_pc: got %h expected 00000000", instr_pc);
        end
    endtask

    task automatic test_stream();
        int k;
        logic expv;
        do_reset();
        #1;
        checks++;
        if (imem_req_valid !== 1'b1) begin
            failures++;
            $display("FAIL first_req: got %b expected 1", imem_req_valid);
        end
        k = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            expv = (i % 2 == 1);
            checks++;
            if (instr_valid !== expv) begin
                failures++;
                $display("FAIL stream_valid[%0d]: got %b expected %b",
                         i, instr_valid, expv);
            end
            if (expv) begin
                checks++;
                if (instr_pc !== 32'(k * 4)) begin
                    failures++;
                    $display("FAIL stream_pc[%0d]: got %h expected %h",
                             i, instr_pc, 32'(k * 4));
                end
                checks++;
                if (instr !== word(32'(k * 4))) begin
                    failures++;
                    $display("FAIL stream_instr[%0d]: got %h expected %h",
                             i, instr, word(32'(k * 4)));
                end
                k++;
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        instr_ready = 1'b0;
        repeat (10) cycle();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL stall_head: got v=%b pc=%h expected v=1 pc=0",
                     instr_valid, instr_pc);
        end
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_req: got %b expected 0", imem_req_valid);
        end
        checks++;
        if (fire_q.size() != DEPTH) begin
            failures++;
            $display("FAIL stall_reqs: got %0d expected %0d",
                     fire_q.size(), DEPTH);
        end
        instr_ready = 1'b1;
        cycle();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h4) begin
            failures++;
            $display("FAIL drain_second: got v=%b pc=%h expected v=1 pc=4",
                     instr_valid, instr_pc);
        end
        cycle();
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty: got %b expected 0", instr_valid);
        end
    endtask

    task automatic test_redirect();
        bit found;
        do_reset();
        mem_lat = 3;
        cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_req: got %b expected 0", imem_req_valid);
        end
        cycle();
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            cycle();
            found = instr_valid;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL redir_timeout: got no instr expected pc 00000100");
        end else begin
            if (instr_pc !== 32'h100 || instr !== word(32'h100)) begin
                failures++;
                $display("FAIL redir_head: got pc=%h i=%h expected pc=%h i=%h",
                         instr_pc, instr, 32'h100, word(32'h100));
            end
        end
    endtask

    task automatic test_collide();
        bit found;
        do_reset();
        instr_ready = 1'b0;
        repeat (3) cycle();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            failures++;
            $display("FAIL coll_setup: got v=%b pc=%h expected v=1 pc=0",
                     instr_valid, instr_pc);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        instr_ready    = 1'b1;
        cycle();
        redirect_valid = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL coll_valid: got %b expected 0", instr_valid);
        end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            failures++;
            $display("FAIL coll_req: got v=%b a=%h expected v=1 a=00000200",
                     imem_req_valid, imem_req_addr);
        end
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            cycle();
            found = instr_valid;
        end
        checks++;
        if (!found || instr_pc !== 32'h200) begin
            failures++;
            $display("FAIL coll_next: got f=%b pc=%h expected f=1 pc=00000200",
                     found, instr_pc);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        cycle();
        redirect_valid = 1'b0;
        repeat (5) cycle();
        checks++;
        if (fire_q.size() < 2) begin
            failures++;
            $display("FAIL wrap_count: got %0d expected >=2", fire_q.size());
        end else begin
            checks++;
            if (fire_q[0] !== 32'hFFFF_FFFC) begin
                failures++;
                $display("FAIL wrap_first: got %h expected fffffffc", fire_q[0]);
            end
            checks++;
            if (fire_q[1] !== 32'h0) begin
                failures++;
                $display("FAIL wrap_next: got %h expected 00000000", fire_q[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        do_reset();
        mem_lat = 3;
        cycle();
        checks++;
        if (fire_q.size() != 1) begin
            failures++;
            $display("FAIL mid_fire: got %0d expected 1", fire_q.size());
        end
        #2 rst = 1'b1;
        @(negedge clk);
        rst            = 1'b0;
        imem_req_ready = 1'b0;
        mem_auto       = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        cycle();
        imem_rsp_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL late_rsp: got %b expected 0", instr_valid);
        end
        mem_auto       = 1'b1;
        lat_cnt        = 0;
        mem_lat        = 1;
        imem_req_ready = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            failures++;
            $display("FAIL restart_req: got v=%b a=%h expected v=1 a=0",
                     imem_req_valid, imem_req_addr);
        end
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            cycle();
            found = instr_valid;
        end
        checks++;
        if (!found || instr_pc !== 32'h0 || instr !== word(32'h0)) begin
            failures++;
            $display("FAIL restart_head: got f=%b pc=%h i=%h expected f=1 pc=0 i=%h",
                     found, instr_pc, instr, word(32'h0));
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_collide();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: instruction buffer entries; legal values are 2 and 4.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port imem_req_valid, output, 1: fetch request to instruction memory.
REQ-006 Port imem_req_ready, input, 1: memory accepts the request this cycle.
REQ-007 Port imem_req_addr, output, 32: word-aligned fetch address (bits [1:0]=0).
REQ-008 Port imem_rsp_valid, input, 1: instruction word returned; always accepted.
REQ-009 Port imem_rsp_data, input, 32: returned instruction word.
REQ-010 Port redirect_valid, input, 1: branch/jump taken; restart fetch.
REQ-011 Port redirect_pc, input, 32: new fetch address; bits [1:0] are ignored and forced to 0.
REQ-012 Port instr_valid, output, 1: buffer head is valid toward decode/immediate extension.
REQ-013 Port instr_ready, input, 1: decode consumes the head this cycle.
REQ-014 Port instr, output, 32: head instruction word; holds In[31:0] for the immediate extender.
REQ-015 Port instr_pc, output, 32: fetch address of the head instruction.

Function
REQ-016 A request transfers when imem_req_valid and imem_req_ready are both 1; a response transfers when imem_rsp_valid is 1.
REQ-017 At most one request is outstanding; a response arrives one or more cycles after its request transfer, in order.
REQ-018 imem_req_valid is 1 only when: no request is outstanding, redirect_valid is 0, and entries occupied plus outstanding is less than DEPTH.
REQ-019 Once asserted, imem_req_valid and imem_req_addr stay stable until the transfer or a redirect.
REQ-020 On a request transfer, fetch_pc increments by 4 (mod 2^32, wraps at 32'hFFFF_FFFC to 0) and the address is recorded as the pending PC.
REQ-021 A non-squashed response enqueues {pending PC, imem_rsp_data} at the tail.
REQ-022 instr_valid equals (count != 0); instr and instr_pc show the head entry and are stable while instr_valid is 1 and instr_ready is 0.
REQ-023 The head dequeues when instr_valid is 1 and instr_ready is 1.
REQ-024 When enqueue and dequeue occur in the same cycle, both take effect and count is unchanged, including when the buffer is full.
REQ-025 A response arriving while full is a protocol violation; it is prevented by REQ-018 and flagged by an assertion.
REQ-026 On a redirect, the same cycle: count becomes 0, fetch_pc becomes redirect_pc, and any outstanding request is marked squashed.
REQ-027 A squashed response is dropped without enqueue and clears the squash flag; the next request may issue the cycle after that response.
REQ-028 A redirect coincident with a response or dequeue takes priority: the response is dropped and the buffer is empty next cycle.
REQ-029 A redirect while instr_valid is 1 means the head is not consumed, even if instr_ready is 1.
REQ-030 Request latency: a request issues the cycle after reset deassertion, and the cycle after a redirect when nothing is outstanding.

Reset
REQ-031 Asserting rst immediately sets: fetch_pc=RESET_PC, count=0, head/tail pointers=0, outstanding=0, squash=0.
REQ-032 During reset all outputs read: imem_req_valid=0, instr_valid=0, imem_req_addr=RESET_PC, instr=0, instr_pc=0.
REQ-033 A response returning after a reset asserted mid-transaction is ignored, because outstanding=0.

Structure
REQ-034 The shared package holds: XLEN=32, INSTR_BYTES=4, NOP_INSTR=32'h0000_0013, and the typedef fetch_entry_t {pc, instr}.
REQ-035 The buffer is one sub-module, fetch_fifo, a synchronous circular FIFO with a flush input; control and PC logic stay in fetch_queue.

Verification
REQ-036 Reset release, memory always ready, 1-cycle response, instr_ready=1 -> instr_pc sequence 0x0, 0x4, 0x8, with one instruction per 2 cycles.
REQ-037 instr_ready=0 for 10 cycles -> exactly DEPTH entries are held, imem_req_valid=0, and the head stays at pc 0x0.
REQ-038 Redirect to 0x100 with a request outstanding -> the stale response is dropped and the next instr_pc is 0x100.
REQ-039 Redirect, enqueue and dequeue in the same cycle -> instr_valid=0 next cycle, and count=0.
REQ-040 redirect_pc=32'hFFFF_FFFC -> the following fetch address is 0x0.
REQ-041 rst pulsed mid-transaction, then a late response -> the response is ignored and fetch restarts at RESET_PC.
